audio_hp_stage: RTL and testbench

- Parametrised multi-channel first-order DC-blocking high-pass stage between the audio codec wrapper's receive bus and transmit bus.
- Per channel: y[n] = x[n] − x[n−1] + (alpha·y[n−1]) >>> (COEF_W−1).
- Channels are time-multiplexed over one shared multiplier, one channel per clock.
- Runtime mode select: bypass, filter, mute, hold. Adds overrun detection when a new frame arrives while the block is busy.

---
 rtl/audio_hp_pkg.sv | 33 +++
 rtl/audio_hp_stage_if.sv | 26 ++
 rtl/hp_channel_mac.sv | 46 ++++
 rtl/audio_hp_stage.sv | 110 +++++++++++
 tb/tb_audio_hp_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/audio_hp_pkg.sv
// Shared types and helpers for the multi-channel DC-blocking high-pass stage.
package audio_hp_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_FILTER = 2'b01,
    MODE_MUTE   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int SAT_MAXW = 64;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [SAT_MAXW-1:0] saturate(
    input logic signed [SAT_MAXW-1:0] v,
    input int                         w
  );
    logic signed [SAT_MAXW-1:0] hi;
    logic signed [SAT_MAXW-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/audio_hp_stage_if.sv
// Frame bus between the codec wrapper and the high-pass stage.
interface audio_hp_stage_if #(
  parameter int CH     = 2,
  parameter int W      = 24,
  parameter int COEF_W = 16
);
  logic                ready_i;
  logic [CH*W-1:0]     din;
  logic [1:0]          mode;
  logic [COEF_W-1:0]   alpha;
  logic                clr_ovr;
  logic [CH*W-1:0]     dout;
  logic                dout_valid;
  logic                busy;
  logic                overrun;

  modport master (
    output ready_i, din, mode, alpha, clr_ovr,
    input  dout, dout_valid, busy, overrun
  );

  modport slave (
    input  ready_i, din, mode, alpha, clr_ovr,
    output dout, dout_valid, busy, overrun
  );
endinterface

// File: rtl/hp_channel_mac.sv
// Combinational single-channel datapath: y = sat(x - x_prev + (alpha*y_prev >>> (COEF_W-1))).
module hp_channel_mac
  import audio_hp_pkg::*;
#(
  parameter int W      = 24,
  parameter int COEF_W = 16
) (
  input  logic signed [W-1:0]      x,
  input  logic signed [W-1:0]      x_prev,
  input  logic signed [W-1:0]      y_prev,
  input  logic signed [COEF_W-1:0] alpha,
  input  mode_t                    mode,
  output logic signed [W-1:0]      result,
  output logic signed [W-1:0]      y_next
);

  logic signed [W:0]          diff;
  logic signed [W+COEF_W-1:0] prod;
  logic signed [W+1:0]        fb;
  logic signed [W+1:0]        sum;
  logic signed [W-1:0]        y_sat;

  always_comb begin
    diff  = {x[W-1], x} - {x_prev[W-1], x_prev};
    prod  = alpha * y_prev;
    // |alpha| <= 1, so the shifted feedback always fits in W+1 bits.
    fb    = (W+2)'(prod >>> (COEF_W - 1));
    sum   = {diff[W], diff} + fb;
    y_sat = W'(saturate({{(SAT_MAXW-W-2){sum[W+1]}}, sum}, W));

    result = y_sat;
    y_next = y_sat;
    case (mode)
      MODE_BYPASS: begin
        result = x;
        y_next = '0;
      end
      MODE_MUTE: begin
        result = '0;
        y_next = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/audio_hp_stage.sv
// Time-multiplexed multi-channel DC-blocking high-pass stage, one channel per clock.
module audio_hp_stage
  import audio_hp_pkg::*;
#(
  parameter int CH     = 2,
  parameter int W      = 24,
  parameter int COEF_W = 16
) (
  input logic              clk,
  input logic              reset_n,
  audio_hp_stage_if.slave  bus
);

  localparam int CH_IDX_W = (CH > 1) ? $clog2(CH) : 1;

  state_t                    state, state_nxt;
  logic [CH_IDX_W-1:0]       ch;
  logic                      capture;
  logic                      last_ch;

  logic signed [W-1:0]       x_cap    [CH];
  logic signed [W-1:0]       x_prev   [CH];
  logic signed [W-1:0]       y_prev   [CH];
  logic signed [W-1:0]       res_bank [CH];
  mode_t                     mode_cap;
  logic signed [COEF_W-1:0]  alpha_cap;

  logic signed [W-1:0]       mac_result;
  logic signed [W-1:0]       mac_y_next;

  logic [CH*W-1:0]           dout_q;
  logic                      dout_valid_q;
  logic                      overrun_q;

  assign last_ch = (ch == CH_IDX_W'(CH - 1));

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: if (bus.ready_i) begin
        state_nxt = CALC;
        capture   = 1'b1;
      end
      CALC:    if (last_ch) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every clocked process uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  hp_channel_mac #(.W(W), .COEF_W(COEF_W)) u_mac (
    .x      (x_cap[ch]),
    .x_prev (x_prev[ch]),
    .y_prev (y_prev[ch]),
    .alpha  (alpha_cap),
    .mode   (mode_cap),
    .result (mac_result),
    .y_next (mac_y_next)
  );

  // NOTE: history and result banks are small flop arrays, not RAM, so they take the async reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CH; i++) begin
        x_cap[i]    <= '0;
        x_prev[i]   <= '0;
        y_prev[i]   <= '0;
        res_bank[i] <= '0;
      end
      mode_cap     <= MODE_BYPASS;
      alpha_cap    <= '0;
      ch           <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (capture) begin
        for (int i = 0; i < CH; i++) x_cap[i] <= bus.din[i*W +: W];
        mode_cap  <= mode_t'(bus.mode);
        alpha_cap <= bus.alpha;
        ch        <= '0;
      end else if (state == CALC) begin
        res_bank[ch] <= mac_result;
        x_prev[ch]   <= x_cap[ch];
        y_prev[ch]   <= mac_y_next;
        ch           <= ch + 1'b1;
      end

      dout_valid_q <= (state == OUT) && (mode_cap != MODE_HOLD);
      if ((state == OUT) && (mode_cap != MODE_HOLD))
        for (int i = 0; i < CH; i++) dout_q[i*W +: W] <= res_bank[i];

      // A new overrun event takes priority over a coincident clear.
      if (bus.ready_i && (state != IDLE)) overrun_q <= 1'b1;
      else if (bus.clr_ovr)               overrun_q <= 1'b0;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = (state != IDLE);
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_audio_hp_stage.sv
// Directed self-checking bench for audio_hp_stage (CH=2/W=24 and CH=4/W=16 builds).
module tb_audio_hp_stage;
  import audio_hp_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  audio_hp_stage_if #(.CH(2), .W(24), .COEF_W(16)) bus_a ();
  audio_hp_stage_if #(.CH(4), .W(16), .COEF_W(12)) bus_b ();

  audio_hp_stage #(.CH(2), .W(24), .COEF_W(16)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  audio_hp_stage #(.CH(4), .W(16), .COEF_W(12)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] pk_a(input logic signed [23:0] c1, input logic signed [23:0] c0);
    return {c1, c0};
  endfunction

  function automatic logic [63:0] pk_b(input logic signed [15:0] c3, input logic signed [15:0] c2,
                                       input logic signed [15:0] c1, input logic signed [15:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  // One frame on DUT A; lat is edges from capture to the dout_valid sample (-1 if none).
  task automatic frame_a(input logic [47:0] d, input logic [1:0] m, input logic [15:0] a,
                         output int lat, output int busy_n);
    @(posedge clk); #1;
    bus_a.ready_i = 1'b1; bus_a.din = d; bus_a.mode = m; bus_a.alpha = a;
    @(posedge clk); #1;
    bus_a.ready_i = 1'b0;
    bus_a.mode    = m ^ 2'b11;
    bus_a.alpha   = '0;
    lat    = -1;
    busy_n = bus_a.busy ? 1 : 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (bus_a.busy) busy_n++;
      if (bus_a.dout_valid && lat < 0) lat = k;
    end
  endtask

  task automatic frame_b(input logic [63:0] d, input logic [11:0] a, output int lat);
    @(posedge clk); #1;
    bus_b.ready_i = 1'b1; bus_b.din = d; bus_b.mode = MODE_FILTER; bus_b.alpha = a;
    @(posedge clk); #1;
    bus_b.ready_i = 1'b0;
    bus_b.alpha   = '0;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (bus_b.dout_valid && lat < 0) lat = k;
    end
  endtask

  initial begin
    int lat;
    int busy_n;

    reset_n = 1'b0;
    bus_a.ready_i = 1'b0; bus_a.din = '0; bus_a.mode = MODE_FILTER; bus_a.alpha = '0; bus_a.clr_ovr = 1'b0;
    bus_b.ready_i = 1'b0; bus_b.din = '0; bus_b.mode = MODE_FILTER; bus_b.alpha = '0; bus_b.clr_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout",    64'(bus_a.dout), 64'd0);
    check("rst_valid",   64'(bus_a.dout_valid), 64'd0);
    check("rst_busy",    64'(bus_a.busy), 64'd0);
    check("rst_overrun", 64'(bus_a.overrun), 64'd0);
    reset_n = 1'b1;

    // Step response, alpha = 0.5: 1000, 500, 250.
    frame_a(pk_a(1000, 1000), MODE_FILTER, 16'd16384, lat, busy_n);
    check("step1_dout", 64'(bus_a.dout), 64'(pk_a(1000, 1000)));
    check("step1_lat",  64'(lat), 64'd3);
    check("step1_busy", 64'(busy_n), 64'd3);
    frame_a(pk_a(1000, 1000), MODE_FILTER, 16'd16384, lat, busy_n);
    check("step2_dout", 64'(bus_a.dout), 64'(pk_a(500, 500)));
    check("step2_lat",  64'(lat), 64'd3);
    frame_a(pk_a(1000, 1000), MODE_FILTER, 16'd16384, lat, busy_n);
    check("step3_dout", 64'(bus_a.dout), 64'(pk_a(250, 250)));

    // Saturation: bypass primes x_prev and clears y_prev, then a full-scale swing clips.
    frame_a(pk_a(24'sd8388607, -24'sd8388608), MODE_BYPASS, 16'd16384, lat, busy_n);
    check("sat_prime", 64'(bus_a.dout), 64'(pk_a(24'sd8388607, -24'sd8388608)));
    frame_a(pk_a(-24'sd8388608, 24'sd8388607), MODE_FILTER, 16'd16384, lat, busy_n);
    check("sat_clip", 64'(bus_a.dout), 64'(pk_a(-24'sd8388608, 24'sd8388607)));

    // Modes.
    frame_a(pk_a(-5, 7), MODE_BYPASS, 16'd0, lat, busy_n);
    check("bypass_dout", 64'(bus_a.dout), 64'(pk_a(-5, 7)));
    check("bypass_lat",  64'(lat), 64'd3);
    frame_a(pk_a(111, 222), MODE_HOLD, 16'd16384, lat, busy_n);
    check("hold_dout",  64'(bus_a.dout), 64'(pk_a(-5, 7)));
    check("hold_valid", 64'(lat), -64'sd1);
    check("hold_busy",  64'(busy_n), 64'd3);
    frame_a(pk_a(9, 9), MODE_MUTE, 16'd16384, lat, busy_n);
    check("mute_dout", 64'(bus_a.dout), 64'd0);
    check("mute_lat",  64'(lat), 64'd3);

    // Overrun: second ready_i one clock after capture is ignored.
    do_reset();
    check("ovr_clear0", 64'(bus_a.overrun), 64'd0);
    @(posedge clk); #1;
    bus_a.ready_i = 1'b1; bus_a.din = pk_a(1000, 1000); bus_a.mode = MODE_FILTER; bus_a.alpha = 16'd16384;
    @(posedge clk); #1;
    bus_a.din = pk_a(5555, 5555);
    @(posedge clk); #1;
    bus_a.ready_i = 1'b0;
    check("ovr_set",  64'(bus_a.overrun), 64'd1);
    check("ovr_busy", 64'(bus_a.busy), 64'd1);
    lat = -1;
    for (int k = 2; k <= 6; k++) begin
      @(posedge clk); #1;
      if (bus_a.dout_valid && lat < 0) lat = k;
    end
    check("ovr_dout", 64'(bus_a.dout), 64'(pk_a(1000, 1000)));
    check("ovr_lat",  64'(lat), 64'd3);
    bus_a.clr_ovr = 1'b1;
    @(posedge clk); #1;
    bus_a.clr_ovr = 1'b0;
    check("ovr_cleared", 64'(bus_a.overrun), 64'd0);

    // Clear coincident with a new overrun event: set wins.
    bus_a.ready_i = 1'b1; bus_a.din = pk_a(1000, 1000);
    @(posedge clk); #1;
    bus_a.clr_ovr = 1'b1;
    @(posedge clk); #1;
    bus_a.ready_i = 1'b0; bus_a.clr_ovr = 1'b0;
    check("ovr_set_wins", 64'(bus_a.overrun), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check("ovr_frame2_dout", 64'(bus_a.dout), 64'(pk_a(500, 500)));
    bus_a.clr_ovr = 1'b1;
    @(posedge clk); #1;
    bus_a.clr_ovr = 1'b0;

    // Reset in the middle of CALC.
    @(posedge clk); #1;
    bus_a.ready_i = 1'b1; bus_a.din = pk_a(3000, 3000); bus_a.mode = MODE_FILTER; bus_a.alpha = 16'd16384;
    @(posedge clk); #1;
    bus_a.ready_i = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy_before", 64'(bus_a.busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_dout",  64'(bus_a.dout), 64'd0);
    check("midrst_busy",  64'(bus_a.busy), 64'd0);
    check("midrst_valid", 64'(bus_a.dout_valid), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    frame_a(pk_a(1000, 1000), MODE_FILTER, 16'd16384, lat, busy_n);
    check("midrst_hist_clr", 64'(bus_a.dout), 64'(pk_a(1000, 1000)));

    // CH=4, W=16, COEF_W=12 build, alpha = 0.5 (1024).
    frame_b(pk_b(-400, 300, -200, 100), 12'd1024, lat);
    check("b_step1_dout", 64'(bus_b.dout), pk_b(-400, 300, -200, 100));
    check("b_step1_lat",  64'(lat), 64'd5);
    frame_b(pk_b(-400, 300, -200, 100), 12'd1024, lat);
    check("b_step2_dout", 64'(bus_b.dout), pk_b(-200, 150, -100, 50));
    check("b_step2_lat",  64'(lat), 64'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
